scan_chain_driver: RTL and testbench

Parallel-to-serial scan test driver sitting directly upstream of a scan-inserted register bank: it accepts a full chain pattern as a parallel word, shifts it into the bank through `scan_in`/`scan_enable`, and runs a functional capture pulse. It then unloads the captured response from the chain tail (`scan_out`) as a parallel word, overlapping the unload with the next pattern load. One instance drives one chain, e.g. the 32-flop bank on the `scan_enable_1`/`scan_in_1` chain.

---
 rtl/scan_drv_pkg.sv | 26 ++
 rtl/scan_drv_sipo.sv | 67 ++++++
 rtl/scan_chain_driver.sv | 143 ++++++++++++++
 tb/tb_scan_chain_driver.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/scan_drv_pkg.sv
`default_nettype none
// ============================================================================
// Module   : scan_drv_pkg
// Purpose  : Shared types and helpers for the scan chain driver.
// Revision : 1.0 - initial release
// ============================================================================
package scan_drv_pkg;

  // Sequencer states of the scan driver.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SHIFT   = 2'd1,
    CAPTURE = 2'd2,
    UNLOAD  = 2'd3
  } scan_drv_state_e;

  // Capture counter width; covers CAPTURE_CYCLES up to 15.
  localparam int CAP_CNT_W = 4;

  // Width of the per-bit shift counter for a chain of n flops.
  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/scan_drv_sipo.sv
`default_nettype none
// ============================================================================
// Module   : scan_drv_sipo
// Purpose  : Unload serial-in/parallel-out register plus a one-deep result
//            slot with valid/ready handshake.
// Revision : 1.0 - initial release
// ============================================================================
module scan_drv_sipo
  import scan_drv_pkg::*;
#(
  parameter int CHAIN_LEN = 32,
  parameter int CNT_W     = cnt_width(CHAIN_LEN)
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 shift_en_i,
  input  logic [CNT_W-1:0]     bit_idx_i,
  input  logic                 sdata_i,
  input  logic                 post_i,
  input  logic                 res_ready_i,
  output logic                 res_valid_o,
  output logic [CHAIN_LEN-1:0] res_data_o,
  output logic                 slot_free_o
);

  logic [CHAIN_LEN-1:0] unload_q;
  logic [CHAIN_LEN-1:0] unload_d;
  logic                 res_valid_q;
  logic [CHAIN_LEN-1:0] res_data_q;

  // Merge the bit arriving on this edge so a post sees the complete word.
  always_comb begin
    unload_d = unload_q;
    if (shift_en_i) begin
      unload_d[bit_idx_i] = sdata_i;
    end
  end

  // Unload register captures the chain tail on every shift edge.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      unload_q <= '0;
    end else begin
      unload_q <= unload_d;
    end
  end

  // Result slot: filled on post, held stable until the consumer takes it.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
    end else if (post_i) begin
      res_valid_q <= 1'b1;
      res_data_q  <= unload_d;
    end else if (res_valid_q && res_ready_i) begin
      res_valid_q <= 1'b0;
    end
  end

  assign res_valid_o = res_valid_q;
  assign res_data_o  = res_data_q;
  // Free either when empty or when being popped on this very edge.
  assign slot_free_o = !res_valid_q || res_ready_i;

endmodule
`default_nettype wire

// File: rtl/scan_chain_driver.sv
`default_nettype none
// ============================================================================
// Module   : scan_chain_driver
// Purpose  : Parallel-to-serial scan test driver: loads a pattern into a scan
//            chain, runs functional capture cycles and unloads the response,
//            overlapping each unload with the next pattern load.
// Revision : 1.0 - initial release
// ============================================================================
module scan_chain_driver
  import scan_drv_pkg::*;
#(
  parameter int CHAIN_LEN      = 32,
  parameter int CAPTURE_CYCLES = 1
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 pattern_valid_i,
  output logic                 pattern_ready_o,
  input  logic [CHAIN_LEN-1:0] pattern_data_i,
  output logic                 result_valid_o,
  input  logic                 result_ready_i,
  output logic [CHAIN_LEN-1:0] result_data_o,
  output logic                 scan_enable_o,
  output logic                 scan_in_o,
  input  logic                 scan_out_i,
  output logic                 busy_o
);

  localparam int                   CNT_W    = cnt_width(CHAIN_LEN);
  localparam logic [CNT_W-1:0]     BIT_LAST = CNT_W'(CHAIN_LEN - 1);
  localparam logic [CAP_CNT_W-1:0] CAP_LAST = CAP_CNT_W'(CAPTURE_CYCLES - 1);

  scan_drv_state_e      state_q;
  logic [CHAIN_LEN-1:0] load_q;      // bits still to be sent, MSB next
  logic [CNT_W-1:0]     bit_cnt_q;
  logic [CAP_CNT_W-1:0] cap_cnt_q;
  logic                 cap_pend_q;  // chain holds a captured response
  logic                 scan_enable_q;
  logic                 scan_in_q;
  logic                 alive_q;     // keeps ready low until first edge out of reset

  logic                 in_scan;
  logic                 last_bit;
  logic                 last_cap;
  logic                 slot_free;
  logic                 accept;
  logic                 post;
  logic [CNT_W-1:0]     bit_idx;

  assign in_scan   = (state_q == SHIFT) || (state_q == UNLOAD);
  assign last_bit  = (bit_cnt_q == BIT_LAST);
  assign last_cap  = (state_q == CAPTURE) && (cap_cnt_q == CAP_LAST);
  assign bit_idx   = BIT_LAST - bit_cnt_q;
  assign post      = in_scan && last_bit && cap_pend_q;

  assign pattern_ready_o = alive_q && slot_free && ((state_q == IDLE) || last_cap);
  assign accept          = pattern_valid_i && pattern_ready_o;

  // Sequencer: shifting, capture window, stall on full slot, registered scan pins.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q       <= IDLE;
      load_q        <= '0;
      bit_cnt_q     <= '0;
      cap_cnt_q     <= '0;
      cap_pend_q    <= 1'b0;
      scan_enable_q <= 1'b0;
      scan_in_q     <= 1'b0;
      alive_q       <= 1'b0;
    end else begin
      alive_q <= 1'b1;
      case (state_q)
        IDLE: begin
          if (accept) begin
            state_q       <= SHIFT;
            bit_cnt_q     <= '0;
            load_q        <= {pattern_data_i[CHAIN_LEN-2:0], 1'b0};
            scan_enable_q <= 1'b1;
            scan_in_q     <= pattern_data_i[CHAIN_LEN-1];
          end
        end
        SHIFT, UNLOAD: begin
          if (last_bit) begin
            state_q       <= (state_q == SHIFT) ? CAPTURE : IDLE;
            cap_pend_q    <= 1'b0;
            cap_cnt_q     <= '0;
            scan_enable_q <= 1'b0;
            scan_in_q     <= 1'b0;
          end else begin
            bit_cnt_q <= bit_cnt_q + CNT_W'(1);
            scan_in_q <= (state_q == SHIFT) && load_q[CHAIN_LEN-1];
            load_q    <= {load_q[CHAIN_LEN-2:0], 1'b0};
          end
        end
        CAPTURE: begin
          // The last capture cycle is held while the result slot is full,
          // since the next scan would post into it.
          if (!last_cap) begin
            cap_cnt_q <= cap_cnt_q + CAP_CNT_W'(1);
          end else if (accept) begin
            state_q       <= SHIFT;
            bit_cnt_q     <= '0;
            load_q        <= {pattern_data_i[CHAIN_LEN-2:0], 1'b0};
            scan_enable_q <= 1'b1;
            scan_in_q     <= pattern_data_i[CHAIN_LEN-1];
            cap_pend_q    <= 1'b1;
          end else if (slot_free) begin
            state_q       <= UNLOAD;
            bit_cnt_q     <= '0;
            scan_enable_q <= 1'b1;
            scan_in_q     <= 1'b0;
            cap_pend_q    <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  scan_drv_sipo #(
    .CHAIN_LEN (CHAIN_LEN),
    .CNT_W     (CNT_W)
  ) u_sipo (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .shift_en_i  (in_scan),
    .bit_idx_i   (bit_idx),
    .sdata_i     (scan_out_i),
    .post_i      (post),
    .res_ready_i (result_ready_i),
    .res_valid_o (result_valid_o),
    .res_data_o  (result_data_o),
    .slot_free_o (slot_free)
  );

  assign scan_enable_o = scan_enable_q;
  assign scan_in_o     = scan_in_q;
  assign busy_o        = (state_q != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_scan_chain_driver.sv
`default_nettype none
// ============================================================================
// Module   : tb_scan_chain_driver
// Purpose  : Self-checking bench for scan_chain_driver with a behavioural
//            scan bank (capture D = ~Q) and a pattern-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_scan_chain_driver;

  localparam int L   = 8;
  localparam int CC  = 1;
  localparam int CC3 = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  logic         reset;
  logic         pv, pr, rv, rr, se, si, so, busy;
  logic [L-1:0] pd, rd;
  logic         pv3, pr3, rv3, rr3, se3, si3, so3, busy3;
  logic [L-1:0] pd3, rd3;

  scan_chain_driver #(.CHAIN_LEN(L), .CAPTURE_CYCLES(CC)) u_dut (
    .clk_i(clk), .reset_i(reset),
    .pattern_valid_i(pv), .pattern_ready_o(pr), .pattern_data_i(pd),
    .result_valid_o(rv), .result_ready_i(rr), .result_data_o(rd),
    .scan_enable_o(se), .scan_in_o(si), .scan_out_i(so), .busy_o(busy)
  );

  scan_chain_driver #(.CHAIN_LEN(L), .CAPTURE_CYCLES(CC3)) u_dut3 (
    .clk_i(clk), .reset_i(reset),
    .pattern_valid_i(pv3), .pattern_ready_o(pr3), .pattern_data_i(pd3),
    .result_valid_o(rv3), .result_ready_i(rr3), .result_data_o(rd3),
    .scan_enable_o(se3), .scan_in_o(si3), .scan_out_i(so3), .busy_o(busy3)
  );

  // Behavioural scan banks: shift when scan_enable is high, else capture ~Q.
  logic [L-1:0] chain  = '0;
  logic [L-1:0] chain3 = '0;
  always @(posedge clk) begin
    chain  <= se  ? {chain[L-2:0], si}   : ~chain;
    chain3 <= se3 ? {chain3[L-2:0], si3} : ~chain3;
  end
  assign so  = chain[L-1];
  assign so3 = chain3[L-1];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Pattern-level reference: a pattern loaded into the bank comes back
  // inverted once per functional edge before the next scan sequence.
  logic [L-1:0] exp_q[$];
  logic [L-1:0] chain_pat, pend_pat, prev_rd;
  bit           chain_full, load_pending, in_shift, is_load, prev_hold;
  int           k, cap_edges, last_gap, n_results;

  initial begin
    chain_full = 0; load_pending = 0; in_shift = 0; is_load = 0; prev_hold = 0;
    k = 0; cap_edges = 0; last_gap = 0; n_results = 0;
    chain_pat = '0; pend_pat = '0; prev_rd = '0;
  end

  always @(negedge clk) begin
    if (reset) begin
      exp_q.delete();
      chain_full = 0; load_pending = 0; in_shift = 0; prev_hold = 0; cap_edges = 0;
    end else begin
      if (se) begin
        if (!in_shift) begin
          if (chain_full)
            exp_q.push_back(chain_pat ^ ((cap_edges % 2 == 1) ? {L{1'b1}} : {L{1'b0}}));
          last_gap     = cap_edges;
          in_shift     = 1;
          k            = 0;
          is_load      = load_pending;
          chain_full   = load_pending;
          chain_pat    = pend_pat;
          load_pending = 0;
        end
        check_eq("scan_in", si, is_load ? chain_pat[L-1-k] : 1'b0);
        k++;
      end else begin
        if (in_shift) begin
          check_eq("shift_len", k, L);
          in_shift  = 0;
          cap_edges = 0;
        end
        cap_edges++;
      end
      if (prev_hold) check_eq("result_hold", rd, prev_rd);
      if (rv && !rr) check_eq("ready_while_full", pr, 1'b0);
      prev_hold = rv && !rr;
      prev_rd   = rd;
      if (rv && rr) begin
        n_results++;
        check_eq("result_expected", exp_q.size() > 0, 1'b1);
        if (exp_q.size() > 0) check_eq("result_data", rd, exp_q.pop_front());
      end
      if (pv && pr) begin
        load_pending = 1;
        pend_pat     = pd;
      end
    end
  end

  // Length of the scan_enable-low run before each shift sequence of dut3.
  int run3 = 0;
  int gap3 = 0;
  always @(negedge clk) begin
    if (reset) run3 = 0;
    else if (se3) begin
      if (run3 > 0) gap3 = run3;
      run3 = 0;
    end else run3++;
  end

  task automatic send(input logic [L-1:0] p, output int acc);
    pd = p;
    pv = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (pr) break;
    end
    check_eq("accept_in_time", pr, 1'b1);
    @(posedge clk); #1;
    acc = cyc;
    pv  = 1'b0;
  endtask

  task automatic wait_result(output int t, output logic [L-1:0] d);
    t = -1;
    d = '0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (rv) begin
        t = cyc;
        d = rd;
        break;
      end
    end
    check_eq("result_in_time", rv, 1'b1);
  endtask

  task automatic drain();
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (!busy && !rv) break;
    end
    check_eq("drain_idle", busy | rv, 1'b0);
  endtask

  task automatic send3(input logic [L-1:0] p, output int acc);
    pd3 = p;
    pv3 = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (pr3) break;
    end
    check_eq("accept3_in_time", pr3, 1'b1);
    @(posedge clk); #1;
    acc = cyc;
    pv3 = 1'b0;
  endtask

  task automatic wait_result3(output logic [L-1:0] d);
    d = '0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (rv3) begin
        d = rd3;
        break;
      end
    end
    check_eq("result3_in_time", rv3, 1'b1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int a1, a2, t1, t2, base;
    logic [L-1:0] d1, d2;
    reset = 1'b1;
    pv = 0; pd = '0; rr = 0;
    pv3 = 0; pd3 = '0; rr3 = 1;

    // Reset state
    repeat (2) @(negedge clk);
    check_eq("rst_pattern_ready", pr, 1'b0);
    check_eq("rst_result_valid", rv, 1'b0);
    check_eq("rst_result_data", rd, 8'h00);
    check_eq("rst_scan_enable", se, 1'b0);
    check_eq("rst_scan_in", si, 1'b0);
    check_eq("rst_busy", busy, 1'b0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_eq("ready_after_reset", pr, 1'b1);

    // Single pattern 0xA5 -> 0x5A, latency from accept edge to post edge
    @(posedge clk); #1;
    rr = 1'b1;
    send(8'hA5, a1);
    @(negedge clk);
    check_eq("busy_active", busy, 1'b1);
    wait_result(t1, d1);
    check_eq("single_result", d1, 8'h5A);
    check_eq("latency", t1 - a1, 2 * L + CC);
    drain();
    check_eq("ready_idle", pr, 1'b1);

    // Back-to-back 0x0F, 0x33 with result_ready held high
    @(posedge clk); #1;
    send(8'h0F, a1);
    send(8'h33, a2);
    check_eq("throughput", a2 - a1, L + CC);
    @(negedge clk);
    @(negedge clk);
    check_eq("overlap_gap", last_gap, CC);
    wait_result(t1, d1);
    wait_result(t2, d2);
    check_eq("b2b_first", d1, 8'hF0);
    check_eq("b2b_second", d2, 8'hCC);
    check_eq("result_gap", t2 - t1, L + CC);
    drain();

    // Back-pressure: slot full stalls the next scan; pop and accept share an edge
    @(posedge clk); #1;
    rr = 1'b0;
    send(8'h3C, a1);
    send(8'h96, a2);
    wait_result(t1, d1);
    check_eq("stall_result", d1, 8'hC3);
    pd = 8'h55;
    pv = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_eq("stall_ready_low", pr, 1'b0);
      check_eq("stall_se_low", se, 1'b0);
    end
    @(posedge clk); #1;
    rr = 1'b1;
    @(negedge clk);
    check_eq("ready_post_pop", pr, 1'b1);
    @(posedge clk); #1;
    pv = 1'b0;
    @(negedge clk);
    check_eq("shift_after_pop", se, 1'b1);
    check_eq("slot_popped", rv, 1'b0);
    drain();

    // Reset during SHIFT cycle 3
    @(posedge clk); #1;
    send(8'h77, a1);
    repeat (3) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check_eq("midrst_scan_enable", se, 1'b0);
    check_eq("midrst_result_valid", rv, 1'b0);
    check_eq("midrst_busy", busy, 1'b0);
    @(negedge clk);
    @(posedge clk); #1;
    reset = 1'b0;
    send(8'hFF, a1);
    wait_result(t1, d1);
    check_eq("post_reset_result", d1, 8'h00);
    drain();

    // pattern_valid pulse during SHIFT is ignored
    @(posedge clk); #1;
    send(8'hC5, a1);
    @(negedge clk);
    check_eq("ready_during_shift", pr, 1'b0);
    pd = 8'h11;
    pv = 1'b1;
    @(posedge clk); #1;
    pv = 1'b0;
    wait_result(t1, d1);
    check_eq("ignored_pulse", d1, 8'h3A);
    drain();
    check_eq("no_extra_results", exp_q.size(), 0);

    // CAPTURE_CYCLES = 3 instance
    send3(8'h3C, a1);
    send3(8'h81, a2);
    check_eq("cc3_period", a2 - a1, L + CC3);
    @(negedge clk);
    @(negedge clk);
    check_eq("cc3_gap", gap3, CC3);
    wait_result3(d1);
    check_eq("cc3_first", d1, 8'hC3);
    wait_result3(d2);
    check_eq("cc3_gap_unload", gap3, CC3);
    check_eq("cc3_second", d2, 8'h7E);

    // Randomised traffic with random back-pressure
    base = n_results;
    for (int i = 0; i < 600; i++) begin
      @(posedge clk); #1;
      pv = ($urandom_range(0, 2) != 0);
      pd = L'($urandom);
      rr = ($urandom_range(0, 3) != 0);
    end
    @(posedge clk); #1;
    pv = 1'b0;
    rr = 1'b1;
    drain();
    check_eq("random_queue_empty", exp_q.size(), 0);
    check_eq("random_results_seen", (n_results - base) > 10, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
